// File: rtl/alu_seq_param.sv
// Multi-cycle WIDTH-bit ALU: add/sub, signed Booth multiply and unsigned
// non-restoring divide, with a one- or two-word result stream.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] in,
  input  logic [1:0]         op_codes,
  input  logic               valid,
  output logic               busy,
  output logic [WIDTH-1:0]   o,
  output logic               o_valid,
  output logic               o_last,
  output logic               ready,
  output logic [2:0]         flags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, EXEC, MUL_STEP, DIV_STEP,
    DIV_FIX, DZ, OUT_HI, OUT_LO
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             qm1;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic [2:0]       flg;

  logic             accept;
  logic             b_zero;
  logic             last_step;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   acc_b;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] hi_word;
  logic [WIDTH-1:0] lo_word;

  logic [WIDTH-1:0] o_nxt;
  logic             ov_nxt;
  logic             ol_nxt;
  logic             rdy_nxt;
  logic             busy_nxt;
  logic [2:0]       flags_nxt;

  assign accept    = (state == IDLE) && valid && !busy;
  assign b_zero    = (in[WIDTH-1:0] == '0);
  assign last_step = (cnt == CNT_LAST);

  // q holds A and m holds B for the single-cycle ops
  assign m_ext  = {m[WIDTH-1], m};
  assign b_ext  = {1'b0, m};
  assign add_s  = {1'b0, q} + {1'b0, m};
  assign sub_s  = {1'b0, q} - {1'b0, m};
  assign acc_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign acc_d  = acc[WIDTH] ? acc_sh + b_ext
                             : acc_sh - b_ext;

  always_comb begin
    acc_b = acc;
    unique case ({q[0], qm1})
      2'b10:   acc_b = acc - m_ext;
      2'b01:   acc_b = acc + m_ext;
      default: acc_b = acc;
    endcase
  end

  assign hi_word = op_r[0] ? q : acc[WIDTH-1:0];
  assign lo_word = (op_r == 2'b11) ? acc[WIDTH-1:0] : q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            !op_codes[1]:                 state_nxt = EXEC;
            op_codes == 2'b10:            state_nxt = MUL_STEP;
            op_codes == 2'b11 && b_zero:  state_nxt = DZ;
            op_codes == 2'b11 && !b_zero: state_nxt = DIV_STEP;
            default:                      state_nxt = IDLE;
          endcase
        end
      end
      EXEC:     state_nxt = OUT_LO;
      MUL_STEP: if (last_step) state_nxt = OUT_HI;
      DIV_STEP: if (last_step) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = OUT_HI;
      DZ:       state_nxt = OUT_HI;
      OUT_HI:   state_nxt = OUT_LO;
      OUT_LO:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_nxt     = '0;
    ov_nxt    = 1'b0;
    ol_nxt    = 1'b0;
    rdy_nxt   = 1'b0;
    busy_nxt  = busy;
    flags_nxt = flags;
    unique case (state)
      IDLE: begin
        if (accept)      busy_nxt = 1'b1;
        else if (o_last) busy_nxt = 1'b0;
      end
      OUT_HI: begin
        o_nxt  = hi_word;
        ov_nxt = 1'b1;
      end
      OUT_LO: begin
        o_nxt     = lo_word;
        ov_nxt    = 1'b1;
        ol_nxt    = 1'b1;
        rdy_nxt   = 1'b1;
        flags_nxt = flg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o       <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      flags   <= '0;
    end else begin
      o       <= o_nxt;
      o_valid <= ov_nxt;
      o_last  <= ol_nxt;
      ready   <= rdy_nxt;
      busy    <= busy_nxt;
      flags   <= flags_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      q    <= '0;
      m    <= '0;
      qm1  <= 1'b0;
      cnt  <= '0;
      op_r <= '0;
      flg  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            q    <= in[2*WIDTH-1:WIDTH];
            m    <= in[WIDTH-1:0];
            acc  <= '0;
            qm1  <= 1'b0;
            cnt  <= '0;
            op_r <= op_codes;
            flg  <= '0;
          end
        end
        EXEC: begin
          if (!op_r[0]) begin
            q   <= add_s[WIDTH-1:0];
            flg <= {1'b0,
                    (q[WIDTH-1] == m[WIDTH-1]) &&
                    (add_s[WIDTH-1] != q[WIDTH-1]),
                    add_s[WIDTH]};
          end else begin
            q   <= sub_s[WIDTH-1:0];
            flg <= {1'b0,
                    (q[WIDTH-1] != m[WIDTH-1]) &&
                    (sub_s[WIDTH-1] != q[WIDTH-1]),
                    sub_s[WIDTH]};
          end
        end
        MUL_STEP: begin
          acc <= {acc_b[WIDTH], acc_b[WIDTH:1]};
          q   <= {acc_b[0], q[WIDTH-1:1]};
          qm1 <= q[0];
          if (!last_step) cnt <= cnt + CW'(1);
        end
        DIV_STEP: begin
          acc <= acc_d;
          q   <= {q[WIDTH-2:0], ~acc_d[WIDTH]};
          if (!last_step) cnt <= cnt + CW'(1);
        end
        DIV_FIX: begin
          if (acc[WIDTH]) acc <= acc + b_ext;
        end
        DZ: begin
          acc <= {1'b0, q};
          q   <= '1;
          flg <= 3'b100;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised and directed checks of alu_seq_param at WIDTH 8 and 16
// against an arithmetic reference model.
module tb_alu_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in8;
  logic [31:0] in16;
  logic [1:0]  op8, op16;
  logic        v8, v16;
  logic        busy8, ov8, ol8, rdy8;
  logic        busy16, ov16, ol16, rdy16;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic [2:0]  fl8, fl16;

  logic        sel16;
  logic [31:0] obs_o;
  logic        obs_ov, obs_ol, obs_rdy, obs_busy;
  logic [2:0]  obs_fl;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .op_codes(op8),
    .valid(v8), .busy(busy8), .o(o8), .o_valid(ov8),
    .o_last(ol8), .ready(rdy8), .flags(fl8)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in(in16), .op_codes(op16),
    .valid(v16), .busy(busy16), .o(o16), .o_valid(ov16),
    .o_last(ol16), .ready(rdy16), .flags(fl16)
  );

  always_comb begin
    obs_o    = sel16 ? {16'b0, o16} : {24'b0, o8};
    obs_ov   = sel16 ? ov16   : ov8;
    obs_ol   = sel16 ? ol16   : ol8;
    obs_rdy  = sel16 ? rdy16  : rdy8;
    obs_busy = sel16 ? busy16 : busy8;
    obs_fl   = sel16 ? fl16   : fl8;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model(
    input int w, input logic [1:0] op,
    input longint a, input longint b,
    output longint w0, output longint w1,
    output int nw, output int fl, output int first);
    longint full, half, sa, sb, r, rs;
    full = longint'(1) << w;
    half = full / 2;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    w1 = 0;
    nw = 1;
    fl = 0;
    first = 2;
    case (op)
      2'd0: begin
        r  = a + b;
        rs = sa + sb;
        w0 = r % full;
        fl = ((r >= full) ? 1 : 0) |
             ((rs >= half || rs < -half) ? 2 : 0);
      end
      2'd1: begin
        r  = a - b + full;
        rs = sa - sb;
        w0 = r % full;
        fl = ((a < b) ? 1 : 0) |
             ((rs >= half || rs < -half) ? 2 : 0);
      end
      2'd2: begin
        r  = sa * sb;
        if (r < 0) r = r + full * full;
        w0 = r / full;
        w1 = r % full;
        nw = 2;
        first = w + 1;
      end
      default: begin
        nw = 2;
        if (b == 0) begin
          w0 = full - 1;
          w1 = a;
          fl = 4;
        end else begin
          w0 = a / b;
          w1 = a % b;
          first = w + 2;
        end
      end
    endcase
  endfunction

  task automatic txn(input int w, input logic [1:0] op,
                     input logic [31:0] a_raw,
                     input logic [31:0] b_raw,
                     input bit tog);
    longint a, b, w0, w1;
    int nw, fl, first, last;
    logic [31:0] ev;
    logic ex_v;
    a = longint'(a_raw) % (longint'(1) << w);
    b = longint'(b_raw) % (longint'(1) << w);
    model(w, op, a, b, w0, w1, nw, fl, first);
    last = first + nw - 1;
    sel16 = (w == 16);
    if (w == 16) begin
      in16 = {a[15:0], b[15:0]};
      op16 = op;
      v16  = 1'b1;
    end else begin
      in8 = {a[7:0], b[7:0]};
      op8 = op;
      v8  = 1'b1;
    end
    @(posedge clk); #1;
    v8  = 1'b0;
    v16 = 1'b0;
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      ex_v = (k == first) || (k == last);
      ev = !ex_v ? 32'd0 :
           (k == first) ? 32'(w0) : 32'(w1);
      check("o_valid", obs_ov, ex_v);
      check("o", obs_o, ev);
      check("o_last", obs_ol, k == last);
      check("ready", obs_rdy, k == last);
      check("busy", obs_busy, k <= last);
      if (k == last) check("flags", obs_fl, fl);
      if (tog && k <= last) begin
        if (w == 16) begin
          v16  = 1'($urandom);
          in16 = $urandom;
          op16 = 2'($urandom);
        end else begin
          v8  = 1'($urandom);
          in8 = 16'($urandom);
          op8 = 2'($urandom);
        end
      end else begin
        v8  = 1'b0;
        v16 = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1;
    v8 = 1'b0; v16 = 1'b0;
    in8 = '0; in16 = '0;
    op8 = '0; op16 = '0;
    sel16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel16 = (s == 1);
      #1;
      check("rst_o", obs_o, 0);
      check("rst_ov", obs_ov, 0);
      check("rst_busy", obs_busy, 0);
      check("rst_rdy", obs_rdy, 0);
      check("rst_fl", obs_fl, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    txn(8, 2'd0, 32'h7F, 32'h01, 0);
    txn(8, 2'd1, 32'h05, 32'h07, 0);
    txn(8, 2'd0, 32'hFF, 32'h01, 0);
    txn(8, 2'd1, 32'h80, 32'h01, 0);
    txn(8, 2'd2, 32'h83, 32'h05, 1);
    txn(8, 2'd2, 32'h80, 32'h80, 0);
    txn(8, 2'd2, 32'hFF, 32'hFF, 0);
    txn(8, 2'd3, 32'd200, 32'd7, 0);
    txn(8, 2'd3, 32'h2A, 32'h00, 0);

    sel16 = 1'b0;
    in8 = {8'h83, 8'h05};
    op8 = 2'd2;
    v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ov", ov8, 0);
    check("abort_o", o8, 0);
    check("abort_busy", busy8, 0);
    check("abort_rdy", rdy8, 0);
    check("abort_fl", fl8, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rdy8 || ov8) seen = 1'b1;
    end
    check("abort_quiet", seen, 0);
    txn(8, 2'd0, 32'd3, 32'd4, 0);

    txn(16, 2'd2, 32'h8000, 32'h8000, 0);
    txn(16, 2'd3, 32'hFFFF, 32'h0010, 0);

    for (int i = 0; i < 40; i++) begin
      int w;
      logic [1:0] op;
      logic [31:0] a, b;
      w  = (i % 2 == 1) ? 16 : 8;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (op == 2'd3 && $urandom_range(0, 1) == 1)
        b = b % 32'd9;
      txn(w, op, a, b, i % 4 == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
